// File: rtl/prio_grant_dec2_4_pkg.sv
// Shared definitions for the request/grant loop: FSM state encoding,
// requester count and index width, plus an index-to-one-hot helper.
package prio_grant_dec2_4_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Turn an encoded requester index into its one-hot grant vector.
  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] i);
    logic [NUM_REQ-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/prio_grant_dec2_4_grant_timer.sv
// Grant-length counter. Cleared while no grant is active, counts grant
// cycles and saturates at TIMEOUT-1 so it can never wrap.
module grant_timer #(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  // Last permitted grant cycle reached.
  assign expired = (cnt == CNT_W'(TIMEOUT - 1));

  // Count grant cycles; hold at the limit instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/prio_grant_dec2_4.sv
// Grant-side companion to the 4-to-2 priority encoder: turns the winning
// index into a registered one-hot grant, holds it until the grantee
// releases or the timer expires, then inserts a single idle gap cycle.
module prio_grant_dec2_4
  import prio_grant_dec2_4_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IDX_W-1:0]   q,
  input  logic               v,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] gnt,
  output logic               busy,
  output logic               ready,
  output logic               tmo,
  output logic [IDX_W-1:0]   last_q
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic               busy_d, ready_d, tmo_d, accept;
  logic               timer_clear, timer_en, expired;

  // The timer only runs during a grant and starts from zero on each new one.
  assign timer_clear = (state_q != ST_GRANT);
  assign timer_en    = (state_q == ST_GRANT);

  grant_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .en     (timer_en),
    .expired(expired)
  );

  // Next state plus the output values for that next state, so every output
  // leaves a flop and no input reaches an output combinationally.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    accept  = 1'b0;
    tmo_d   = 1'b0;
    gnt_d   = '0;
    busy_d  = 1'b0;
    ready_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (v) begin
          accept  = 1'b1;
          idx_d   = q;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (done[idx_q]) begin
          state_d = ST_GAP;
        end else if (expired) begin
          state_d = ST_GAP;
          tmo_d   = 1'b1;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    case (state_d)
      ST_IDLE: begin
        ready_d = 1'b1;
      end
      ST_GRANT: begin
        gnt_d  = idx_to_onehot(idx_d);
        busy_d = 1'b1;
      end
      ST_GAP: begin
        busy_d = 1'b1;
      end
      default: begin
        ready_d = 1'b0;
      end
    endcase
  end

  // State, captured index and registered outputs; reset drops any grant silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      gnt     <= '0;
      busy    <= 1'b0;
      ready   <= 1'b1;
      tmo     <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (accept) begin
        last_q <= q;
      end
      gnt     <= gnt_d;
      busy    <= busy_d;
      ready   <= ready_d;
      tmo     <= tmo_d;
    end
  end

endmodule

// File: doc/prio_grant_dec2_4.md
# prio_grant_dec2_4

Grant-side companion to the 4-to-2 priority encoder. It accepts the encoder's winning index `q` and valid `v`, and returns a registered one-hot grant to the selected requester. It holds that grant until the requester signals `done` or a timeout expires, then enforces one idle gap cycle before accepting the next request. It sits between the priority encoder output and the four requesters, closing the request/grant loop.

## Interface
- `TIMEOUT`, default 8: maximum grant length in cycles; legal range 1..255.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `q`  in  2  encoded index of the highest-priority requester, from the encoder.
- `v`  in  1  `q` valid; at least one request pending.
- `done`  in  4  per-requester release; only the bit of the current grantee is honoured.
- `gnt`  out  4  registered one-hot grant, `gnt = 1 << idx` while granting; else 0.
- `busy`  out  1  registered; 1 in GRANT and GAP.
- `ready`  out  1  registered; 1 in IDLE only.
- `tmo`  out  1  registered one-cycle pulse when a grant ends by timeout.
- `last_q`  out  2  index of the most recent accepted request; held until the next accept.

## Operation
- States:
  - IDLE: `ready=1`, `gnt=0`, `busy=0`.
  - GRANT: `gnt=1<<idx`, `busy=1`.
  - GAP: `gnt=0`, `busy=1`, `ready=0`.
- IDLE, `v=1` at an edge:
  - capture `q` into `idx` and `last_q`;
  - clear the counter;
  - go to GRANT.
- IDLE, `v=0`: stay in IDLE.
- GRANT, each edge:
  - `done[idx]=1`: go to GAP; `tmo` stays 0.
  - else if `cnt == TIMEOUT-1`: go to GAP; pulse `tmo` for the next cycle.
  - else: increment `cnt`, stay in GRANT.
- GAP: exactly one cycle, then IDLE unconditionally.
- `v` and `q` are ignored outside IDLE. A request present during GRANT or GAP is picked up on the first IDLE edge where `v=1`.
- `done` bits other than `done[idx]` are ignored in every state. All `done` bits are ignored in IDLE and GAP.
- If `done[idx]=1` in the same cycle the timeout is reached, `done` wins and no `tmo` pulse is produced.
- Counter width is `$clog2(TIMEOUT+1)`. The counter never wraps; it is cleared on entry to GRANT.
- `rst=1` at any edge, including mid-grant:
  - state goes to IDLE;
  - `gnt=0`, `busy=0`, `ready=1`, `tmo=0`, `last_q=0`, `cnt=0`.
  - Any grant in progress is dropped with no `tmo` pulse.

## Timing
- Accept latency: `v` sampled at edge k drives `gnt` from edge k onward, i.e. visible in cycle k+1.
- Release latency: `done[idx]` sampled at edge m clears `gnt` from edge m.
- Grant duration:
  - 1 cycle minimum, when `done[idx]` is present in the first GRANT cycle;
  - exactly `TIMEOUT` cycles when `done[idx]` never arrives.
- Minimum spacing between two accepts is 3 edges (IDLE→GRANT→GAP→IDLE). With `v` held high and immediate `done`, `gnt` is high 1 cycle in 3.
- `tmo` is high for exactly one cycle, coincident with the GAP cycle.
- No combinational path from any input to any output.

## Structure
- Shared package holds:
  - state encoding constants `ST_IDLE=2'd0`, `ST_GRANT=2'd1`, `ST_GAP=2'd2`;
  - the requester count constant (4) and its index width (2).
  - The priority encoder and this block both use it.
- Sub-module `grant_timer`:
  - inputs: `clk`, `rst`, `clear`, `en`;
  - output: `expired`;
  - `expired` is high when `cnt == TIMEOUT-1`;
  - parameterised by `TIMEOUT`.
- The top module keeps the FSM, the `idx`/`last_q` registers and the output registers.

## Test plan
- Reset, then `v=1`, `q=2` for one cycle, `done[2]=1` in the first GRANT cycle:
  - `gnt=4'b0100` for 1 cycle, then `busy=1` for 1 GAP cycle;
  - then `ready=1`; `last_q=2`; `tmo=0`.
- `TIMEOUT=8`, `q=1`, `done` held 0:
  - `gnt=4'b0010` for exactly 8 cycles;
  - `tmo=1` for 1 cycle, then IDLE.
- `q=3` granted, `done=4'b0111` held for 4 cycles, then `done[3]=1`:
  - wrong bits ignored; `gnt=4'b1000` held 5 cycles;
  - release with no `tmo`.
- `done[idx]=1` exactly in cycle `TIMEOUT`: release with `tmo=0`.
- `v=1` held continuously, `q` stepping 0,1,2,3, immediate `done`:
  - grants 0001, 0010, 0100, 1000, one every 3 cycles;
  - `q` changes during GRANT/GAP have no effect.
- `rst=1` during cycle 3 of a grant:
  - next cycle `gnt=0`, `busy=0`, `ready=1`, `last_q=0`, `tmo=0`;
  - a new `v=1` is accepted on the following edge.
